// File: rtl/core_dec_pkg.sv
// rtl/core_dec_pkg.sv - shared types and encodings for the decode stage
package core_dec_pkg;

  localparam logic [6:0] OP       = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] LOAD     = 7'b0000011;
  localparam logic [6:0] STORE    = 7'b0100011;
  localparam logic [6:0] BRANCH   = 7'b1100011;
  localparam logic [6:0] LUI      = 7'b0110111;
  localparam logic [6:0] AUIPC    = 7'b0010111;
  localparam logic [6:0] JAL      = 7'b1101111;
  localparam logic [6:0] JALR     = 7'b1100111;
  localparam logic [6:0] SYSTEM   = 7'b1110011;
  localparam logic [6:0] MISC_MEM = 7'b0001111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // instr[31:7] patterns for SYSTEM with func3 = 000
  localparam logic [24:0] SYS_ECALL  = 25'h0000000;
  localparam logic [24:0] SYS_EBREAK = 25'h0002000;
  localparam logic [24:0] SYS_MRET   = 25'h0604000;

  // alu_op = {func7[5], func3}, so ADD is all zeros
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SLL = 4'b0001;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SRA = 4'b1101;

  typedef enum logic [2:0] {
    MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
  } muldiv_op_e;

  typedef struct packed {
    logic        reg_write;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_read;
    logic        rs2_read;
    logic        branch;
    logic [2:0]  branch_op;
    logic        jal;
    logic        jalr;
    logic        alu_op1_sel_zero;
    logic        alu_op1_sel_pc;
    logic        alu_op2_sel_4;
    logic        alu_op2_sel_imm;
    logic [3:0]  alu_op;
    logic [31:0] imm;
    logic        csr_read;
    logic        csr_write;
    logic [2:0]  csr_op;
    logic [11:0] csr_addr;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  mem_op;
    logic        muldiv;
    muldiv_op_e  muldiv_op;
    logic        mret;
    logic        ecall;
    logic        ebreak;
    logic        fence;
    logic        ill_instr;
  } dec_info_t;

endpackage

// File: rtl/decode_logic.sv
// rtl/decode_logic.sv - combinational RV32I/Zicsr/M instruction decoder
module decode_logic
  import core_dec_pkg::*;
#(
  parameter bit SUPPORT_M   = 1'b1,
  parameter bit SUPPORT_CSR = 1'b1
) (
  input  logic [31:0] instr,
  output dec_info_t   dec
);

  logic [6:0]  opcode;
  logic [6:0]  func7;
  logic [2:0]  func3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        ill;

  assign opcode = instr[6:0];
  assign func7  = instr[31:25];
  assign func3  = instr[14:12];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    dec          = '0;
    ill          = 1'b0;
    dec.rd       = instr[11:7];
    dec.rs1      = instr[19:15];
    dec.rs2      = instr[24:20];
    dec.csr_addr = instr[31:20];
    case (opcode)
      LUI: begin
        dec.reg_write        = 1'b1;
        dec.alu_op1_sel_zero = 1'b1;
        dec.alu_op2_sel_imm  = 1'b1;
        dec.imm              = imm_u;
      end
      AUIPC: begin
        dec.reg_write       = 1'b1;
        dec.alu_op1_sel_pc  = 1'b1;
        dec.alu_op2_sel_imm = 1'b1;
        dec.imm             = imm_u;
      end
      JAL: begin
        dec.jal            = 1'b1;
        dec.reg_write      = 1'b1;
        dec.alu_op1_sel_pc = 1'b1;
        dec.alu_op2_sel_4  = 1'b1;
        dec.imm            = imm_j;
      end
      JALR: begin
        dec.jalr           = 1'b1;
        dec.reg_write      = 1'b1;
        dec.rs1_read       = 1'b1;
        dec.alu_op1_sel_pc = 1'b1;
        dec.alu_op2_sel_4  = 1'b1;
        dec.imm            = imm_i;
        ill                = (func3 != 3'b000);
      end
      BRANCH: begin
        dec.branch    = 1'b1;
        dec.branch_op = func3;
        dec.rs1_read  = 1'b1;
        dec.rs2_read  = 1'b1;
        dec.imm       = imm_b;
        ill           = (func3[2:1] == 2'b01);
      end
      LOAD: begin
        dec.mem_read        = 1'b1;
        dec.mem_op          = func3;
        dec.reg_write       = 1'b1;
        dec.rs1_read        = 1'b1;
        dec.alu_op2_sel_imm = 1'b1;
        dec.imm             = imm_i;
        ill                 = (func3 == 3'b011) || (func3[2:1] == 2'b11);
      end
      STORE: begin
        dec.mem_write       = 1'b1;
        dec.mem_op          = func3;
        dec.rs1_read        = 1'b1;
        dec.rs2_read        = 1'b1;
        dec.alu_op2_sel_imm = 1'b1;
        dec.imm             = imm_s;
        ill                 = func3[2] || (func3[1:0] == 2'b11);
      end
      OP_IMM: begin
        dec.reg_write       = 1'b1;
        dec.rs1_read        = 1'b1;
        dec.alu_op2_sel_imm = 1'b1;
        dec.imm             = imm_i;
        if (func3 == 3'b001) begin
          if (func7 == F7_BASE) dec.alu_op = ALU_SLL;
          else                  ill = 1'b1;
        end else if (func3 == 3'b101) begin
          if (func7 == F7_BASE)     dec.alu_op = ALU_SRL;
          else if (func7 == F7_ALT) dec.alu_op = ALU_SRA;
          else                      ill = 1'b1;
        end else begin
          dec.alu_op = {1'b0, func3};
        end
      end
      OP: begin
        dec.reg_write = 1'b1;
        dec.rs1_read  = 1'b1;
        dec.rs2_read  = 1'b1;
        if (func7 == F7_BASE) begin
          dec.alu_op = {1'b0, func3};
        end else if (func7 == F7_ALT && (func3 == 3'b000 || func3 == 3'b101)) begin
          dec.alu_op = {1'b1, func3};
        end else if (func7 == F7_MULDIV && SUPPORT_M) begin
          dec.muldiv    = 1'b1;
          dec.muldiv_op = muldiv_op_e'(func3);
        end else begin
          ill = 1'b1;
        end
      end
      MISC_MEM: dec.fence = 1'b1;
      SYSTEM: begin
        if (func3 == 3'b000) begin
          if (instr[31:7] == SYS_ECALL)       dec.ecall  = 1'b1;
          else if (instr[31:7] == SYS_EBREAK) dec.ebreak = 1'b1;
          else if (instr[31:7] == SYS_MRET)   dec.mret   = 1'b1;
          else                                ill = 1'b1;
        end else if (func3 == 3'b100 || !SUPPORT_CSR) begin
          ill = 1'b1;
        end else begin
          // CSRRW with rd=x0 skips the read; set/clear with a zero source skips the write
          dec.csr_op    = func3;
          dec.csr_read  = !(func3[1:0] == 2'b01 && instr[11:7] == 5'd0);
          dec.csr_write = (func3[1:0] == 2'b01) || (instr[19:15] != 5'd0);
          dec.reg_write = 1'b1;
          dec.rs1_read  = !func3[2];
          if (func3[2]) dec.imm = {27'b0, instr[19:15]};
        end
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      dec.reg_write = 1'b0;
      dec.mem_read  = 1'b0;
      dec.mem_write = 1'b0;
      dec.csr_write = 1'b0;
      dec.muldiv    = 1'b0;
    end
    dec.ill_instr = ill;
  end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered decode stage with a 2-entry skid buffer
module decode_stage
  import core_dec_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter bit          SUPPORT_M   = 1'b1,
  parameter bit          SUPPORT_CSR = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output dec_info_t       out_dec
);

  dec_info_t       in_dec;
  dec_info_t       s_dec;
  logic [XLEN-1:0] s_pc;
  logic            m_valid, s_valid, s_valid_n, ready_q;
  logic            accept, drain;

  decode_logic #(
    .SUPPORT_M  (SUPPORT_M),
    .SUPPORT_CSR(SUPPORT_CSR)
  ) u_decode_logic (
    .instr(in_instr),
    .dec  (in_dec)
  );

  assign accept    = in_valid & ready_q;
  assign drain     = m_valid & out_ready;
  assign out_valid = m_valid;
  assign in_ready  = ready_q;

  // S only ever holds data while M is full, so M empty implies S empty
  always_comb begin
    s_valid_n = s_valid;
    if (flush)                  s_valid_n = 1'b0;
    else if (!m_valid || drain) s_valid_n = s_valid & accept;
    else if (accept)            s_valid_n = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      ready_q <= 1'b0;
      out_pc  <= '0;
      out_dec <= '0;
      s_pc    <= '0;
      s_dec   <= '0;
    end else begin
      s_valid <= s_valid_n;
      ready_q <= ~s_valid_n;
      if (flush) begin
        m_valid <= 1'b0;
      end else if (!m_valid || drain) begin
        if (s_valid) begin
          m_valid <= 1'b1;
          out_pc  <= s_pc;
          out_dec <= s_dec;
          if (accept) begin
            s_pc  <= in_pc;
            s_dec <= in_dec;
          end
        end else begin
          m_valid <= accept;
          if (accept) begin
            out_pc  <= in_pc;
            out_dec <= in_dec;
          end
        end
      end else if (accept) begin
        s_pc  <= in_pc;
        s_dec <= in_dec;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage
module tb_decode_stage;
  import core_dec_pkg::*;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, out_ready;
  logic [31:0] in_instr, in_pc;
  logic        in_ready, out_valid, nom_ready, nom_valid;
  logic [31:0] out_pc, nom_pc;
  dec_info_t   out_dec, nom_dec;
  int          n_cmp = 0;
  int          n_bad = 0;

  // flags = {mem_read, jal, branch, muldiv, fence, ebreak, ecall, mret}
  localparam logic [31:0] V_INSTR [16] = '{
    32'h002081B3, 32'h402081B3, 32'h027302B3, 32'h40109093,
    32'h00000073, 32'h00100073, 32'h0FF0000F, 32'hFE000EE3,
    32'h001000EF, 32'h4030D093, 32'h402091B3, 32'h30200073,
    32'h00004073, 32'h300312F3, 32'hFFC12083, 32'h00000000};
  localparam logic        V_ILL [16] = '{0,0,0,1, 0,0,0,0, 0,0,1,0, 1,0,0,1};
  localparam logic        V_RW  [16] = '{1,1,1,0, 0,0,0,0, 1,1,0,0, 0,1,1,0};
  localparam logic [31:0] V_IMM [16] = '{
    32'h0, 32'h0, 32'h0, 32'h401, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFC,
    32'h800, 32'h403, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFC, 32'h0};
  localparam logic [3:0]  V_ALU [16] = '{0,8,0,0, 0,0,0,0, 0,4'hD,0,0, 0,0,0,0};
  localparam logic [7:0]  V_FLG [16] = '{
    8'h00, 8'h00, 8'h10, 8'h00, 8'h02, 8'h04, 8'h08, 8'h20,
    8'h40, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h80, 8'h00};

  decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_dec(out_dec)
  );

  decode_stage #(.SUPPORT_M(1'b0)) dut_nom (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(nom_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(nom_valid), .out_ready(out_ready), .out_pc(nom_pc), .out_dec(nom_dec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] flags_of(input dec_info_t d);
    return {d.mem_read, d.jal, d.branch, d.muldiv, d.fence, d.ebreak, d.ecall, d.mret};
  endfunction

  task automatic push(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    step();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_pc = '0;
    step(); step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_dec", out_dec, 0);
    rst = 1'b0;
    step();
    chk("post_rst_in_ready", in_ready, 1);

    // streaming at one bundle per cycle
    for (int i = 0; i < 16; i++) begin
      push(V_INSTR[i], 32'h100 + 32'(4 * i));
      chk($sformatf("valid[%0d]", i), out_valid, 1);
      chk($sformatf("ready[%0d]", i), in_ready, 1);
      chk($sformatf("pc[%0d]", i), out_pc, 32'h100 + 32'(4 * i));
      chk($sformatf("ill[%0d]", i), out_dec.ill_instr, V_ILL[i]);
      chk($sformatf("rw[%0d]", i), out_dec.reg_write, V_RW[i]);
      chk($sformatf("imm[%0d]", i), out_dec.imm, V_IMM[i]);
      chk($sformatf("alu[%0d]", i), out_dec.alu_op, V_ALU[i]);
      chk($sformatf("flags[%0d]", i), flags_of(out_dec), V_FLG[i]);
      chk($sformatf("nom_pc[%0d]", i), nom_pc, 32'h100 + 32'(4 * i));
      if (i == 0) begin
        chk("add_rd", out_dec.rd, 3);
        chk("add_rs1", out_dec.rs1, 1);
        chk("add_rs2", out_dec.rs2, 2);
      end
      if (i == 2) begin
        chk("mul_op", out_dec.muldiv_op, MD_MUL);
        chk("nom_valid", nom_valid, 1);
        chk("nom_ready", nom_ready, 1);
        chk("nom_mul_ill", nom_dec.ill_instr, 1);
        chk("nom_mul_rw", nom_dec.reg_write, 0);
        chk("nom_mul_muldiv", nom_dec.muldiv, 0);
      end
      if (i == 13) chk("csr_addr", out_dec.csr_addr, 12'h300);
    end
    in_valid = 1'b0;
    step();
    chk("drain_empty", out_valid, 0);

    // backpressure: M, then S, then in_ready drops
    out_ready = 1'b0;
    push(V_INSTR[0], 32'h200);
    chk("bp1_pc", out_pc, 32'h200);
    chk("bp1_ready", in_ready, 1);
    push(V_INSTR[1], 32'h204);
    chk("bp2_ready", in_ready, 0);
    chk("bp2_pc", out_pc, 32'h200);
    push(V_INSTR[14], 32'h208);
    chk("bp3_ready", in_ready, 0);
    chk("bp3_hold_pc", out_pc, 32'h200);
    chk("bp3_hold_alu", out_dec.alu_op, 0);
    out_ready = 1'b1;
    step();
    chk("bp_out2_pc", out_pc, 32'h204);
    chk("bp_out2_alu", out_dec.alu_op, 8);
    chk("bp_out2_ready", in_ready, 1);
    step();
    chk("bp_out3_pc", out_pc, 32'h208);
    chk("bp_out3_flags", flags_of(out_dec), 8'h80);
    in_valid = 1'b0;
    step();
    chk("bp_empty", out_valid, 0);

    // flush with M and S full and a new instruction offered
    out_ready = 1'b0;
    push(V_INSTR[0], 32'h300);
    push(V_INSTR[1], 32'h304);
    chk("fl_full_ready", in_ready, 0);
    flush = 1'b1;
    push(V_INSTR[2], 32'h308);
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", out_valid, 0);
    chk("fl_ready", in_ready, 1);
    out_ready = 1'b1;
    step();
    chk("fl_after1", out_valid, 0);
    step();
    chk("fl_after2", out_valid, 0);

    // flush while an accept would otherwise happen
    out_ready = 1'b0;
    push(V_INSTR[0], 32'h400);
    chk("fl2_ready", in_ready, 1);
    flush = 1'b1;
    push(V_INSTR[1], 32'h404);
    flush = 1'b0; in_valid = 1'b0;
    chk("fl2_valid", out_valid, 0);
    step();
    chk("fl2_discard", out_valid, 0);

    // reset mid-backpressure
    push(V_INSTR[0], 32'h500);
    push(V_INSTR[1], 32'h504);
    in_valid = 1'b0;
    chk("mr_full_ready", in_ready, 0);
    rst = 1'b1;
    step();
    chk("mr_valid", out_valid, 0);
    chk("mr_ready", in_ready, 0);
    chk("mr_pc", out_pc, 0);
    rst = 1'b0;
    step();
    chk("mr_ready_after", in_ready, 1);
    chk("mr_valid_after", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
